// File: rtl/dout_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dout_mem_pkg
// Brief   : Shared types and default geometry for the output pixel memory.
// Revision: 1.0
// ============================================================================
package dout_mem_pkg;

    localparam int DEF_WIDTH  = 24;
    localparam int DEF_AMOUNT = 90000;
    localparam int DEF_PIXEL  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DUMP = 1'b1
    } dump_state_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dout_mem_array.sv
`default_nettype none
// ============================================================================
// Module  : dout_mem_array
// Brief   : AMOUNT x PIXEL storage: one write port, async debug read, sync dump read.
// Revision: 1.0
// ============================================================================
module dout_mem_array
    import dout_mem_pkg::*;
#(
    parameter int AMOUNT = DEF_AMOUNT,
    parameter int PIXEL  = DEF_PIXEL,
    parameter int IDX_W  = idx_bits(DEF_AMOUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wa,
    input  logic [PIXEL-1:0] i_wd,
    input  logic [IDX_W-1:0] i_ra,
    output logic [PIXEL-1:0] o_rd,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_sa,
    output logic [PIXEL-1:0] o_sd
);

    logic [PIXEL-1:0] r_mem [AMOUNT];
    logic [PIXEL-1:0] r_sd;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Only the output register is reset; the contents survive rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sd <= '0;
        end else if (i_re) begin
            r_sd <= r_mem[i_sa];
        end
    end

    assign o_rd = r_mem[i_ra];
    assign o_sd = r_sd;

endmodule
`default_nettype wire

// File: rtl/dout_mem.sv
`default_nettype none
// ============================================================================
// Module  : dout_mem
// Brief   : Output pixel memory with address writes and a valid/ready dump engine.
// Revision: 1.0
// ============================================================================
module dout_mem
    import dout_mem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AMOUNT = DEF_AMOUNT,
    parameter int PIXEL  = DEF_PIXEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] ra,
    output logic [WIDTH-1:0] rd,
    input  logic             dump_start,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_addr,
    output logic [PIXEL-1:0] out_pixel,
    output logic             done,
    output logic [WIDTH-1:0] wr_count,
    output logic             err
);

    localparam int               c_IDX_W  = idx_bits(AMOUNT);
    localparam logic [WIDTH-1:0] c_AMOUNT = WIDTH'(AMOUNT);
    localparam logic [WIDTH-1:0] c_ONE    = WIDTH'(1);

    dump_state_t      r_state;
    dump_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_addr;
    logic [WIDTH-1:0] r_wr_count;
    logic             r_out_valid;
    logic             r_done;
    logic             r_err;
    logic             w_busy;
    logic             w_start;
    logic             w_load;
    logic             w_drain;
    logic             w_wr_ok;
    logic             w_wr_bad;
    logic [PIXEL-1:0] w_dbg_pix;
    logic [PIXEL-1:0] w_dump_pix;
    logic             w_wd_unused;

    assign w_wd_unused = ^wd[WIDTH-1:PIXEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (dump_start) w_state_nxt = DUMP;
            DUMP:    if (w_drain)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A beat is loaded whenever the output slot is empty or being emptied.
    always_comb begin
        w_busy  = (r_state == DUMP);
        w_start = (r_state == IDLE) && dump_start;
        w_load  = w_busy && (!r_out_valid || out_ready) && (r_ptr < c_AMOUNT);
        w_drain = w_busy && r_out_valid && out_ready && (r_ptr == c_AMOUNT);
    end

    assign w_wr_ok  = we && (a < c_AMOUNT) && !w_busy;
    assign w_wr_bad = we && !((a < c_AMOUNT) && !w_busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_wr_count  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_done <= w_drain;
            if (w_wr_ok && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + c_ONE;
            end
            if (w_wr_bad) begin
                r_err <= 1'b1;
            end
            if (w_start) begin
                r_ptr <= '0;
            end else if (w_load) begin
                r_ptr       <= r_ptr + c_ONE;
                r_out_addr  <= r_ptr;
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    dout_mem_array #(
        .AMOUNT (AMOUNT),
        .PIXEL  (PIXEL),
        .IDX_W  (c_IDX_W)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .i_we (w_wr_ok),
        .i_wa (a[c_IDX_W-1:0]),
        .i_wd (wd[PIXEL-1:0]),
        .i_ra (ra[c_IDX_W-1:0]),
        .o_rd (w_dbg_pix),
        .i_re (w_load),
        .i_sa (r_ptr[c_IDX_W-1:0]),
        .o_sd (w_dump_pix)
    );

    assign rd        = (ra < c_AMOUNT) ? WIDTH'(w_dbg_pix) : '0;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_pixel = w_dump_pix;
    assign done      = r_done;
    assign wr_count  = r_wr_count;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dout_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_dout_mem
// Brief   : Self-checking bench for dout_mem with a reduced image size.
// Revision: 1.0
// ============================================================================
module tb_dout_mem;

    localparam int WIDTH  = 24;
    localparam int AMOUNT = 1000;
    localparam int PIXEL  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             we = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] wd = '0;
    logic [WIDTH-1:0] ra = '0;
    logic [WIDTH-1:0] rd;
    logic             dump_start = 1'b0;
    logic             busy;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_addr;
    logic [PIXEL-1:0] out_pixel;
    logic             done;
    logic [WIDTH-1:0] wr_count;
    logic             err;

    always #5 clk = ~clk;

    dout_mem #(.WIDTH(WIDTH), .AMOUNT(AMOUNT), .PIXEL(PIXEL)) dut (
        .clk(clk), .rst(rst), .we(we), .a(a), .wd(wd), .ra(ra), .rd(rd),
        .dump_start(dump_start), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_pixel(out_pixel),
        .done(done), .wr_count(wr_count), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: image contents, counters and the expected next beat index.
    logic [7:0] m_mem   [AMOUNT];
    bit         m_known [AMOUNT];
    bit         m_busy = 0, m_done = 0, m_err = 0;
    int         m_wr = 0, m_exp = 0;
    bit         busy_before, acc;

    logic             s_valid = 1'b0, s_ready = 1'b0, s_rst = 1'b1;
    logic [WIDTH-1:0] s_addr = '0;
    logic [PIXEL-1:0] s_pix = '0;
    bit               chk_en = 0;
    bit               rand_mode = 0;
    logic             ready_lvl = 1'b1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_lvl;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_wr = 0; m_exp = 0;
        end else begin
            busy_before = m_busy;
            m_done = 0;
            acc = m_busy && s_valid && out_ready;
            if (we) begin
                if (a < AMOUNT && !busy_before) begin
                    m_mem[a] = wd[7:0];
                    m_known[a] = 1;
                    if (m_wr < (1 << WIDTH) - 1) m_wr++;
                end else begin
                    m_err = 1;
                end
            end
            if (acc) begin
                m_exp++;
                if (m_exp == AMOUNT) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (!busy_before && dump_start) begin
                m_busy = 1;
                m_exp = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("wr_count", 32'(wr_count), 32'(m_wr));
            chk("err", 32'(err), 32'(m_err));
            if (ra >= AMOUNT) chk("rd_oob", 32'(rd), 32'd0);
            else if (m_known[ra]) chk("rd", 32'(rd), 32'(m_mem[ra]));
            if (!m_busy) chk("valid_when_idle", 32'(out_valid), 32'd0);
            if (out_valid) begin
                chk("beat_addr", 32'(out_addr), 32'(m_exp));
                if (m_exp < AMOUNT && m_known[m_exp])
                    chk("beat_pixel", 32'(out_pixel), 32'(m_mem[m_exp]));
            end
            if (s_valid && !s_ready && !s_rst) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_addr", 32'(out_addr), 32'(s_addr));
                chk("hold_pixel", 32'(out_pixel), 32'(s_pix));
            end
        end
        s_valid = out_valid; s_ready = out_ready; s_rst = rst;
        s_addr = out_addr; s_pix = out_pixel;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [WIDTH-1:0] data);
        a = WIDTH'(addr);
        wd = data;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    int beats, gaps, accepts, holds, nd;
    bit seen;
    logic [WIDTH-1:0] last_addr;

    initial begin
        rst = 1'b1;
        step();
        chk_en = 1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);

        step();
        wr(0, 24'h0000AB);
        wr(1, 24'hFFFF12);
        wr(AMOUNT - 1, 24'h00007F);
        ra = '0;
        @(negedge clk); chk("rd_0", 32'(rd), 32'h0000AB);
        step(); ra = 24'd1;
        @(negedge clk); chk("rd_1", 32'(rd), 32'h000012);
        step(); ra = WIDTH'(AMOUNT - 1);
        @(negedge clk); chk("rd_last", 32'(rd), 32'h00007F);
        chk("wr_count_3", 32'(wr_count), 32'd3);
        chk("err_clean", 32'(err), 32'd0);
        step(); ra = WIDTH'(AMOUNT);
        @(negedge clk); chk("rd_out_of_range", 32'(rd), 32'd0);

        step();
        wr(AMOUNT, 24'h000055);
        @(negedge clk);
        chk("err_range", 32'(err), 32'd1);
        chk("wr_count_kept", 32'(wr_count), 32'd3);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk); chk("err_cleared", 32'(err), 32'd0);

        step();
        for (int i = 0; i < AMOUNT; i++) wr(i, WIDTH'(i));

        // Full dump with the consumer always ready; a write to 5 is attempted mid-dump.
        ra = 24'd5;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        @(negedge clk);
        chk("lat0_valid", 32'(out_valid), 32'd0);
        chk("lat0_busy", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        chk("lat1_valid", 32'(out_valid), 32'd1);
        chk("lat1_addr", 32'(out_addr), 32'd0);
        chk("lat1_pixel", 32'(out_pixel), 32'd0);
        beats = 1; gaps = 0; seen = 0; last_addr = '0;
        for (int c = 0; c < 3 * AMOUNT && !seen; c++) begin
            @(posedge clk); #1;
            we = (c == 10);
            a = 24'd5;
            wd = 24'h0000EE;
            @(negedge clk);
            if (done) begin
                seen = 1;
                chk("done_valid_low", 32'(out_valid), 32'd0);
                chk("done_after_last", 32'(last_addr), 32'(AMOUNT - 1));
            end else if (out_valid) begin
                beats++;
                last_addr = out_addr;
            end else begin
                gaps++;
            end
        end
        step(); we = 1'b0;
        chk("dump_done_seen", 32'(seen), 32'd1);
        chk("dump_beats", 32'(beats), 32'(AMOUNT));
        chk("dump_gaps", 32'(gaps), 32'd0);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("busy_write_ignored", 32'(rd), 32'h000005);
        chk("err_busy", 32'(err), 32'd1);

        // Random backpressure: ordering and hold stability come from the compare process.
        step();
        rand_mode = 1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        accepts = 0; holds = 0; seen = 0;
        for (int c = 0; c < 10 * AMOUNT && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                if (out_valid && out_ready) accepts++;
                if (out_valid && !out_ready) holds++;
            end
        end
        chk("bp_done_seen", 32'(seen), 32'd1);
        chk("bp_accepts", 32'(accepts), 32'(AMOUNT));
        chk("bp_holds_seen", 32'(holds > 0), 32'd1);
        rand_mode = 0;
        ready_lvl = 1'b1;

        // Abort by reset after 100 accepted beats, then restart with a same-cycle write.
        step(); step();
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        accepts = 0;
        for (int c = 0; c < 4 * AMOUNT && accepts < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) accepts++;
        end
        chk("abort_reached", 32'(accepts), 32'd100);
        step(); rst = 1'b1;
        step();
        @(negedge clk);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        step(); rst = 1'b0;
        nd = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);

        step();
        we = 1'b1; a = '0; wd = 24'h00005A; dump_start = 1'b1;
        step();
        we = 1'b0; dump_start = 1'b0;
        @(negedge clk);
        chk("restart_lat0", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_addr", 32'(out_addr), 32'd0);
        chk("restart_pixel", 32'(out_pixel), 32'h5A);
        seen = 0;
        for (int c = 0; c < 3 * AMOUNT && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("restart_done_seen", 32'(seen), 32'd1);

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
